reset_seq: RTL and testbench
============================

RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter N_OUT, default 4: number of sequenced reset outputs.
REQ-002 SHALL have parameter HOLD_CYC, default 4: cycles all outputs are held asserted before sequencing begins (at least 1).
REQ-003 SHALL have parameter DLY_W, default 8: width of the inter-stage delay input.
REQ-004 SHALL have port i_clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_stage_dly, input, DLY_W: inter-stage delay, sampled on entry to each stage.
REQ-007 SHALL have port i_sw_rst_req, input, 1: software reset request, a single-cycle pulse.
REQ-008 SHALL have port i_wdt_rst, input, 1: watchdog reset request, a single-cycle pulse.
REQ-009 SHALL have port o_rst, output, N_OUT: active-high resets to downstream domains; bit 0 releases first.
REQ-010 SHALL have port o_busy, output, 1: high while any o_rst bit is asserted.
REQ-011 SHALL have port o_sw_rst_ack, output, 1: one-cycle acknowledge of an accepted software request.
REQ-012 SHALL have port o_cause, output, 2: last reset cause; 00 = POR, 01 = SW, 10 = WDT.

Function
REQ-013 SHALL assert on i_rst_n low and deassert through a 2-FF synchronizer (rst_sync); while rst_sync is low the FSM SHALL stay in HOLD with counters at 0.
REQ-014 SHALL implement the FSM states HOLD, RELEASE and DONE.
REQ-015 HOLD SHALL keep all o_rst = 1 and count HOLD_CYC cycles once rst_sync is high, then go to RELEASE with cnt = 0, idx = 0 and dly_lat = i_stage_dly.
REQ-016 RELEASE SHALL increment cnt each cycle.
REQ-017 When cnt == dly_lat in RELEASE, the FSM SHALL clear o_rst[idx] at that edge, set cnt to 0, increment idx and re-sample dly_lat; each stage therefore takes dly_lat+1 cycles.
REQ-018 o_rst[k] SHALL deassert exactly HOLD_CYC + sum over j=0..k of (dly_j+1) cycles after the first cycle in which rst_sync is seen high.
REQ-019 When idx == N_OUT-1 is released, the FSM SHALL go to DONE at the same edge; o_busy SHALL drop in the same cycle that o_rst becomes all-zero.
REQ-020 i_stage_dly = 0 SHALL release one stage per cycle; the maximum value 2^DLY_W-1 SHALL work without counter overflow, since cnt is DLY_W bits wide.
REQ-021 i_sw_rst_req in DONE SHALL be accepted: o_sw_rst_ack = 1 for one cycle, all o_rst = 1 and state = HOLD at the next edge, o_cause = 01.
REQ-022 i_sw_rst_req in HOLD or RELEASE SHALL be ignored with no ack.
REQ-023 i_wdt_rst SHALL be accepted in any state: all o_rst = 1 and state = HOLD with counters cleared at the next edge, o_cause = 10.
REQ-024 i_wdt_rst SHALL take priority over a simultaneous i_sw_rst_req; in that case there is no ack and o_cause = 10.
REQ-025 Once released, o_rst bits SHALL never re-deassert out of order; any restart SHALL re-assert all bits together.
REQ-026 SHALL keep o_cause across software and watchdog restarts; only i_rst_n SHALL set it to 00.

Reset
REQ-027 On i_rst_n low, the block SHALL immediately (asynchronously) set o_rst = all-ones, o_busy = 1, o_sw_rst_ack = 0, o_cause = 00, state = HOLD, cnt = 0, idx = 0.
REQ-028 Assertion of i_rst_n low mid-RELEASE or in DONE SHALL behave identically to a power-on reset.

Verification
REQ-029 POR: N_OUT = 4, HOLD_CYC = 4, i_stage_dly = 3 -> o_rst falls 4'b1110, 1100, 1000, 0000 at 8, 12, 16 and 20 cycles after rst_sync rises; o_busy falls at 20; o_cause = 00.
REQ-030 Zero delay: i_stage_dly = 0 -> o_rst bits fall on consecutive cycles 5, 6, 7, 8; no skipped or double-stepped stage.
REQ-031 SW reset: pulse i_sw_rst_req in DONE -> o_sw_rst_ack for one cycle, o_rst = 4'b1111 at the next edge, full sequence repeats, o_cause = 01; a second pulse while busy gets no ack.
REQ-032 WDT mid-sequence: i_wdt_rst when o_rst = 4'b1100 -> o_rst = 4'b1111 at the next edge, HOLD restarts, o_cause = 10; simultaneous SW+WDT -> no ack, o_cause = 10.
REQ-033 Async reset mid-RELEASE: drop i_rst_n between clock edges -> o_rst = 4'b1111 and o_cause = 00 without a clock edge; release after 2 sync cycles + the normal sequence.
REQ-034 Delay re-sample: change i_stage_dly from 3 to 1 during stage 1 -> stage 1 still takes 4 cycles, stage 2 takes 2.

Source files
------------

// File: rtl/reset_seq.sv
// Reset sequencer: holds all downstream resets, then releases them one stage at a
// time with a programmable inter-stage delay. Supports software and watchdog restarts.
module reset_seq #(
  parameter int N_OUT    = 4,
  parameter int HOLD_CYC = 4,
  parameter int DLY_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DLY_W-1:0] i_stage_dly,
  input  logic             i_sw_rst_req,
  input  logic             i_wdt_rst,
  output logic [N_OUT-1:0] o_rst,
  output logic             o_busy,
  output logic             o_sw_rst_ack,
  output logic [1:0]       o_cause
);

  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int HC_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_OUT - 1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYC - 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  typedef enum logic [1:0] {HOLD, RELEASE, DONE} state_t;

  state_t           state;
  logic [1:0]       sync_ff;
  logic             rst_sync;
  logic [HC_W-1:0]  hold_cnt;
  logic [DLY_W-1:0] cnt;
  logic [DLY_W-1:0] dly_lat;
  logic [IDX_W-1:0] idx;
  logic             restart;

  // Assertion is asynchronous; release is brought into the clock domain by two flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_ff <= 2'b00;
    else          sync_ff <= {sync_ff[0], 1'b1};
  end
  assign rst_sync = sync_ff[1];

  // Watchdog wins over software; software is only honoured once the sequence is done.
  assign restart = i_wdt_rst || (i_sw_rst_req && (state == DONE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= HOLD;
      hold_cnt     <= '0;
      cnt          <= '0;
      idx          <= '0;
      dly_lat      <= '0;
      o_rst        <= '1;
      o_busy       <= 1'b1;
      o_sw_rst_ack <= 1'b0;
      o_cause      <= CAUSE_POR;
    end else begin
      o_sw_rst_ack <= 1'b0;
      if (restart) begin
        state    <= HOLD;
        hold_cnt <= '0;
        cnt      <= '0;
        idx      <= '0;
        o_rst    <= '1;
        o_busy   <= 1'b1;
        if (i_wdt_rst) begin
          o_cause <= CAUSE_WDT;
        end else begin
          o_cause      <= CAUSE_SW;
          o_sw_rst_ack <= 1'b1;
        end
      end else begin
        case (state)
          HOLD: begin
            if (!rst_sync) begin
              hold_cnt <= '0;
            end else if (hold_cnt == HOLD_LAST) begin
              state    <= RELEASE;
              hold_cnt <= '0;
              cnt      <= '0;
              idx      <= '0;
              dly_lat  <= i_stage_dly;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (cnt == dly_lat) begin
              o_rst[idx] <= 1'b0;
              cnt        <= '0;
              dly_lat    <= i_stage_dly;
              if (idx == LAST_IDX) begin
                state  <= DONE;
                o_busy <= 1'b0;
                idx    <= '0;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
          end
          default: state <= HOLD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: release timing, restarts, async reset and delay re-sampling.
module tb_reset_seq;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic [7:0] i_stage_dly = 8'd3;
  logic       i_sw_rst_req = 1'b0;
  logic       i_wdt_rst = 1'b0;
  logic [3:0] o_rst;
  logic       o_busy;
  logic       o_sw_rst_ack;
  logic [1:0] o_cause;

  int n_pass = 0;
  int n_total = 0;
  int fall[4];
  int busy_fall;
  int ack_cnt;

  always #5 i_clk = ~i_clk;

  reset_seq #(.N_OUT(4), .HOLD_CYC(4), .DLY_W(8)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_stage_dly(i_stage_dly),
    .i_sw_rst_req(i_sw_rst_req),
    .i_wdt_rst(i_wdt_rst),
    .o_rst(o_rst),
    .o_busy(o_busy),
    .o_sw_rst_ack(o_sw_rst_ack),
    .o_cause(o_cause)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Asynchronous reset pulse; returns just after the first edge that sees rst_sync high.
  task automatic do_por();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    tick();
  endtask

  // Records the cycle (relative to a reference edge) at which each output falls.
  task automatic measure(input int start, input int limit);
    for (int k = 0; k < 4; k++) fall[k] = -1;
    busy_fall = -1;
    ack_cnt = 0;
    for (int c = start + 1; c <= limit; c++) begin
      tick();
      for (int k = 0; k < 4; k++)
        if (fall[k] < 0 && o_rst[k] == 1'b0) fall[k] = c;
      if (busy_fall < 0 && o_busy == 1'b0) busy_fall = c;
      if (o_sw_rst_ack) ack_cnt++;
      if (o_rst == 4'b0000 && !o_busy) break;
    end
  endtask

  task automatic test_reset();
    int exp_f[4] = '{8, 12, 16, 20};
    #2 i_rst_n = 1'b0;
    #1;
    n_total++; if (o_rst !== 4'b1111) $display("FAIL reset_rst got %b want 1111", o_rst); else n_pass++;
    n_total++; if (o_busy !== 1'b1) $display("FAIL reset_busy got %b want 1", o_busy); else n_pass++;
    n_total++; if (o_sw_rst_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", o_sw_rst_ack); else n_pass++;
    n_total++; if (o_cause !== 2'b00) $display("FAIL reset_cause got %b want 00", o_cause); else n_pass++;
    i_stage_dly = 8'd3;
    do_por();
    measure(0, 40);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (fall[k] !== exp_f[k]) $display("FAIL por_bit%0d got cycle %0d want %0d", k, fall[k], exp_f[k]);
      else n_pass++;
    end
    n_total++; if (busy_fall !== 20) $display("FAIL por_busy got cycle %0d want 20", busy_fall); else n_pass++;
    n_total++; if (o_cause !== 2'b00) $display("FAIL por_cause got %b want 00", o_cause); else n_pass++;
    $display("test_reset: falls %0d %0d %0d %0d busy %0d", fall[0], fall[1], fall[2], fall[3], busy_fall);
  endtask

  task automatic test_zero_delay();
    int exp_f[4] = '{5, 6, 7, 8};
    i_stage_dly = 8'd0;
    do_por();
    measure(0, 40);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (fall[k] !== exp_f[k]) $display("FAIL zero_bit%0d got cycle %0d want %0d", k, fall[k], exp_f[k]);
      else n_pass++;
    end
    n_total++; if (busy_fall !== 8) $display("FAIL zero_busy got cycle %0d want 8", busy_fall); else n_pass++;
    $display("test_zero_delay: falls %0d %0d %0d %0d", fall[0], fall[1], fall[2], fall[3]);
  endtask

  task automatic test_sw_reset();
    int exp_f[4] = '{8, 12, 16, 20};
    i_stage_dly = 8'd3;
    i_sw_rst_req = 1'b1;
    tick();
    i_sw_rst_req = 1'b0;
    n_total++; if (o_sw_rst_ack !== 1'b1) $display("FAIL sw_ack got %b want 1", o_sw_rst_ack); else n_pass++;
    n_total++; if (o_rst !== 4'b1111) $display("FAIL sw_rst got %b want 1111", o_rst); else n_pass++;
    n_total++; if (o_busy !== 1'b1) $display("FAIL sw_busy got %b want 1", o_busy); else n_pass++;
    n_total++; if (o_cause !== 2'b01) $display("FAIL sw_cause got %b want 01", o_cause); else n_pass++;
    tick();
    n_total++; if (o_sw_rst_ack !== 1'b0) $display("FAIL sw_ack_one_cycle got %b want 0", o_sw_rst_ack); else n_pass++;
    tick();
    i_sw_rst_req = 1'b1;
    tick();
    i_sw_rst_req = 1'b0;
    n_total++; if (o_sw_rst_ack !== 1'b0) $display("FAIL sw_busy_ack got %b want 0", o_sw_rst_ack); else n_pass++;
    measure(3, 40);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (fall[k] !== exp_f[k]) $display("FAIL sw_bit%0d got cycle %0d want %0d", k, fall[k], exp_f[k]);
      else n_pass++;
    end
    n_total++; if (ack_cnt !== 0) $display("FAIL sw_late_ack got %0d acks want 0", ack_cnt); else n_pass++;
    n_total++; if (o_cause !== 2'b01) $display("FAIL sw_cause_kept got %b want 01", o_cause); else n_pass++;
    $display("test_sw_reset: falls %0d %0d %0d %0d", fall[0], fall[1], fall[2], fall[3]);
  endtask

  task automatic test_wdt();
    int exp_f[4] = '{8, 12, 16, 20};
    int c = 0;
    i_stage_dly = 8'd3;
    do_por();
    while (o_rst !== 4'b1100 && c < 40) begin
      tick();
      c++;
    end
    n_total++; if (c !== 12) $display("FAIL wdt_reach_1100 got cycle %0d want 12", c); else n_pass++;
    i_wdt_rst = 1'b1;
    tick();
    i_wdt_rst = 1'b0;
    n_total++; if (o_rst !== 4'b1111) $display("FAIL wdt_rst got %b want 1111", o_rst); else n_pass++;
    n_total++; if (o_cause !== 2'b10) $display("FAIL wdt_cause got %b want 10", o_cause); else n_pass++;
    n_total++; if (o_busy !== 1'b1) $display("FAIL wdt_busy got %b want 1", o_busy); else n_pass++;
    measure(0, 40);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (fall[k] !== exp_f[k]) $display("FAIL wdt_bit%0d got cycle %0d want %0d", k, fall[k], exp_f[k]);
      else n_pass++;
    end
    i_sw_rst_req = 1'b1;
    i_wdt_rst = 1'b1;
    tick();
    i_sw_rst_req = 1'b0;
    i_wdt_rst = 1'b0;
    n_total++; if (o_sw_rst_ack !== 1'b0) $display("FAIL both_ack got %b want 0", o_sw_rst_ack); else n_pass++;
    n_total++; if (o_cause !== 2'b10) $display("FAIL both_cause got %b want 10", o_cause); else n_pass++;
    n_total++; if (o_rst !== 4'b1111) $display("FAIL both_rst got %b want 1111", o_rst); else n_pass++;
    measure(0, 40);
    n_total++; if (fall[3] !== 20) $display("FAIL both_bit3 got cycle %0d want 20", fall[3]); else n_pass++;
    $display("test_wdt: restart reached 1100 at %0d, last fall %0d", c, fall[3]);
  endtask

  task automatic test_async_mid();
    int exp_f[4] = '{8, 12, 16, 20};
    int c = 0;
    i_sw_rst_req = 1'b1;
    tick();
    i_sw_rst_req = 1'b0;
    n_total++; if (o_cause !== 2'b01) $display("FAIL async_pre_cause got %b want 01", o_cause); else n_pass++;
    while (o_rst !== 4'b1100 && c < 40) begin
      tick();
      c++;
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_total++; if (o_rst !== 4'b1111) $display("FAIL async_rst got %b want 1111", o_rst); else n_pass++;
    n_total++; if (o_cause !== 2'b00) $display("FAIL async_cause got %b want 00", o_cause); else n_pass++;
    n_total++; if (o_busy !== 1'b1) $display("FAIL async_busy got %b want 1", o_busy); else n_pass++;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    n_total++; if (o_rst !== 4'b1111) $display("FAIL async_sync_hold got %b want 1111", o_rst); else n_pass++;
    tick();
    measure(0, 40);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (fall[k] !== exp_f[k]) $display("FAIL async_bit%0d got cycle %0d want %0d", k, fall[k], exp_f[k]);
      else n_pass++;
    end
    $display("test_async_mid: falls %0d %0d %0d %0d", fall[0], fall[1], fall[2], fall[3]);
  endtask

  task automatic test_resample();
    int exp_f[4] = '{0, 12, 14, 16};
    int c = 0;
    i_stage_dly = 8'd3;
    do_por();
    while (o_rst !== 4'b1110 && c < 40) begin
      tick();
      c++;
    end
    n_total++; if (c !== 8) $display("FAIL resample_stage0 got cycle %0d want 8", c); else n_pass++;
    i_stage_dly = 8'd1;
    measure(8, 40);
    for (int k = 1; k < 4; k++) begin
      n_total++;
      if (fall[k] !== exp_f[k]) $display("FAIL resample_bit%0d got cycle %0d want %0d", k, fall[k], exp_f[k]);
      else n_pass++;
    end
    $display("test_resample: falls %0d %0d %0d %0d", c, fall[1], fall[2], fall[3]);
  endtask

  task automatic test_max_delay();
    int exp_f[4] = '{260, 516, 772, 1028};
    i_stage_dly = 8'd255;
    do_por();
    measure(0, 1100);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (fall[k] !== exp_f[k]) $display("FAIL max_bit%0d got cycle %0d want %0d", k, fall[k], exp_f[k]);
      else n_pass++;
    end
    n_total++; if (busy_fall !== 1028) $display("FAIL max_busy got cycle %0d want 1028", busy_fall); else n_pass++;
    $display("test_max_delay: falls %0d %0d %0d %0d", fall[0], fall[1], fall[2], fall[3]);
  endtask

  initial begin
    test_reset();
    test_zero_delay();
    test_sw_reset();
    test_wdt();
    test_async_mid();
    test_resample();
    test_max_delay();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
